// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// with an inter-frame gap and a watchdog that aborts a transmitter that never completes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int TIMEOUT_CLKS = 100000,
  parameter int GAP_CLKS     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [DATA_BITS-1:0]           uart_tx_data,
  output logic                           uart_tx_en,
  input  logic                           uart_tx_done,
  output logic                           uart_tx_rst,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
  localparam int GW  = $clog2(GAP_CLKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tmo_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic            w_found;
  logic [IDW-1:0]  w_pick;

  // Scan from the farthest candidate back to the nearest so the requester right
  // after the last grant overwrites everyone else and wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_found = 1'b0;
    w_pick  = grant_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(grant_id) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_pick  = IDW'((int'(grant_id) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tmo_cnt    <= '0;
      r_gap_cnt    <= '0;
      req_ready    <= '0;
      req_done     <= '0;
      uart_tx_data <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_rst  <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= IDW'(NUM_REQ - 1);
      timeout_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here turn the pulse outputs into one-cycle strobes;
      // a later assignment in the same block overrides them for that edge only.
      req_ready   <= '0;
      req_done    <= '0;
      uart_tx_rst <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            uart_tx_data <= req_data[w_pick*DATA_BITS +: DATA_BITS];
            grant_id     <= w_pick;
            req_ready    <= NUM_REQ'(1) << w_pick;
            uart_tx_en   <= 1'b1;
            busy         <= 1'b1;
            r_tmo_cnt    <= '0;
            r_state      <= S_SEND;
          end
        end

        S_SEND: begin
          if (uart_tx_done) begin
            req_done   <= NUM_REQ'(1) << grant_id;
            uart_tx_en <= 1'b0;
            r_gap_cnt  <= GW'(GAP_CLKS - 1);
            r_state    <= S_GAP;
          end else if (r_tmo_cnt == TW'(TIMEOUT_CLKS - 1)) begin
            // This edge is the TIMEOUT_CLKS-th cycle in SEND without completion.
            uart_tx_en  <= 1'b0;
            uart_tx_rst <= 1'b1;
            timeout_err <= 1'b1;
            r_gap_cnt   <= GW'(GAP_CLKS - 1);
            r_state     <= S_GAP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == '0) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N byte-producing requesters (debug console, CPU MMIO port, trace dumper, ...) using round-robin arbitration.
- Latches the granted byte and holds the transmitter's data/enable inputs for a whole frame.
- Waits for the transmitter's one-cycle frame-done pulse, then releases the line.
- Includes a watchdog that aborts and resets a transmitter that never reports completion.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_BITS, 8, bits per UART data word
- TIMEOUT_CLKS, 100000, max clk cycles in SEND before abort (must exceed one full frame time)
- GAP_CLKS, 2, idle cycles with uart_tx_en low between frames (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte pending; held until req_ready[i]
- req_data  in  NUM_REQ*DATA_BITS  byte of requester i at bits [i*DATA_BITS +: DATA_BITS]
- req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i latched
- req_done  out  NUM_REQ  one-cycle pulse: frame of requester i completed on the line
- uart_tx_data  out  DATA_BITS  byte to transmitter, stable for whole SEND
- uart_tx_en  out  1  transmitter enable, high for the whole SEND state only
- uart_tx_done  in  1  one-cycle frame-complete pulse from transmitter
- uart_tx_rst  out  1  one-cycle transmitter reset pulse, asserted on timeout
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(NUM_REQ)  index of current or last granted requester
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset

Behaviour:
- Reset values:
  - req_ready=0, req_done=0, uart_tx_data=0, uart_tx_en=0, uart_tx_rst=0, busy=0, timeout_err=0.
  - grant_id=NUM_REQ-1, so requester 0 has first priority after reset.
  - State = IDLE; timeout and gap counters = 0.
- All outputs are registered.
- Reset mid-frame: return to IDLE on the next edge and drop uart_tx_en. No req_done is pulsed; the interrupted byte is lost.

States:
- IDLE:
  - If any req_valid bit is set, choose the first set bit scanning upward from grant_id+1 with wrap NUM_REQ-1 -> 0.
  - Same edge: latch the chosen byte into uart_tx_data, set grant_id, pulse req_ready[i], go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - uart_tx_en=1, timeout counter increments each cycle.
  - On uart_tx_done=1: pulse req_done[grant_id] on the next cycle, set uart_tx_en=0, load the gap counter, go to GAP.
  - If the counter reaches TIMEOUT_CLKS before done: set uart_tx_en=0, pulse uart_tx_rst, set timeout_err, no req_done, go to GAP.
  - If done and timeout coincide in the same cycle, done wins: normal completion, no error.
- GAP:
  - uart_tx_en=0 for exactly GAP_CLKS cycles, then IDLE.
  - Requests arriving during GAP wait; arbitration is evaluated only in IDLE.

Rules:
- Latency: request seen in IDLE -> req_ready pulse 1 cycle later -> uart_tx_en high in the same cycle as req_ready.
- Back-to-back traffic: at most one byte per frame + GAP_CLKS + 1 cycles.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 frames.
- req_data is sampled only at grant. Changes afterwards do not affect the byte in flight.
- Dropping req_valid before req_ready withdraws the request. No grant occurs if all bits are low in IDLE.
- uart_tx_done outside SEND is ignored.
- Timeout counter width is $clog2(TIMEOUT_CLKS+1). It clears on every entry to SEND.

Test Plan:
- Single request: req_valid=0001, req_data[7:0]=0xA5 -> req_ready=0001 one cycle later; uart_tx_en=1 with uart_tx_data=0xA5 until the done pulse; req_done=0001 once; uart_tx_en low for 2 cycles.
- Round-robin: all four requesters valid with 0x10/0x11/0x12/0x13 held after each grant -> grant order 0,1,2,3,0; req_done pulses in that order; exactly one req_ready per grant.
- Fairness with wrap: grant_id=2, req_valid=1011 -> next grant is 3, then 0, then 1; requester 2 is skipped while not valid.
- Timeout: TIMEOUT_CLKS=50, uart_tx_done tied 0 -> at SEND cycle 50 uart_tx_en=0, uart_tx_rst pulses once, timeout_err=1 and stays 1, no req_done; next request is still served normally.
- Done/timeout collision: done asserted exactly on cycle TIMEOUT_CLKS -> req_done pulses, timeout_err stays 0, no uart_tx_rst.
- Reset mid-SEND plus stray done: reset asserted during SEND -> next cycle uart_tx_en=0, busy=0, grant_id=3; a uart_tx_done pulse in IDLE produces no req_done.
